multiplier_datapath_tainttrack: RTL and testbench

MULTIPLIER_DATAPATH_TAINTTRACK -- requirements
Module: multiplier_datapath_tainttrack

---
 rtl/multiplier_datapath_tainttrack.sv | 138 +++++++++++++
 tb/tb_multiplier_datapath_tainttrack.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_datapath_tainttrack.sv
// -----------------------------------------------------------------------------
// multiplier_datapath_tainttrack
//
// Datapath of a shift-add multiplier with per-bit taint tracking. The control
// FSM lives outside this block and drives the register strobes. Every data
// register has a shadow taint register of the same width. Each taint bit marks
// the matching data bit as derived from tainted inputs or tainted control.
//
// Registers:
//   MD (WIDTH)      multiplicand
//   MR (WIDTH)      multiplier, fed back to the control FSM
//   RS (2*WIDTH+1)  running sum / product; bit 2*WIDTH holds the adder carry
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   taint_kill                    (only with DATAPATH_TAINT_KILL_EN) clears
//                                 all taint registers at the next edge
//   multiplicand / _t             operand A and its taint
//   multiplier / _t               operand B and its taint
//   mdld, mrld / _t               load strobes for MD and MR
//   rsclear, rsload, rsshr / _t   RS operations, priority clear > load > shift
//   multiplierReg / _t            MR and its taint
//   product / _t                  RS[2*WIDTH-1:0] and its taint
//
// Optional feature macro: DATAPATH_TAINT_KILL_EN
// -----------------------------------------------------------------------------
module multiplier_datapath_tainttrack #(
    parameter int WIDTH = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef DATAPATH_TAINT_KILL_EN
    input  logic                 taint_kill,
`endif
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplicand_t,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplier_t,
    input  logic                 mdld,
    input  logic                 mdld_t,
    input  logic                 mrld,
    input  logic                 mrld_t,
    input  logic                 rsclear,
    input  logic                 rsclear_t,
    input  logic                 rsload,
    input  logic                 rsload_t,
    input  logic                 rsshr,
    input  logic                 rsshr_t,
    output logic [WIDTH-1:0]     multiplierReg,
    output logic [WIDTH-1:0]     multiplierReg_t,
    output logic [2*WIDTH-1:0]   product,
    output logic [2*WIDTH-1:0]   product_t
);

    logic [WIDTH-1:0]   md_q, md_d, md_t_q, md_t_d;
    logic [WIDTH-1:0]   mr_q, mr_d, mr_t_q, mr_t_d;
    logic [2*WIDTH:0]   rs_q, rs_d, rs_t_q, rs_t_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     sum_t;
    logic               rs_ctl_t;

    // A tainted sum bit i can depend on every lower operand bit through the
    // carry chain, so its taint is the prefix-OR of both operand taints. The
    // carry bit sees the whole operand width.
    always_comb begin
        logic acc;
        acc   = 1'b0;
        sum_t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            acc      = acc | rs_t_q[WIDTH+i] | md_t_q[i];
            sum_t[i] = acc;
        end
        sum_t[WIDTH] = acc;
    end

    assign sum = {1'b0, rs_q[2*WIDTH-1:WIDTH]} + {1'b0, md_q};

    // Any asserted RS control taint taints the whole RS register. This holds
    // whether or not its strobe is active and whatever its priority, because
    // a tainted strobe means we cannot trust which operation really happened.
    assign rs_ctl_t = rsclear_t | rsload_t | rsshr_t;

    always_comb begin
        md_d   = mdld ? multiplicand : md_q;
        md_t_d = (mdld ? multiplicand_t : md_t_q) | {WIDTH{mdld_t}};

        mr_d   = mrld ? multiplier : mr_q;
        mr_t_d = (mrld ? multiplier_t : mr_t_q) | {WIDTH{mrld_t}};

        rs_d   = rs_q;
        rs_t_d = rs_t_q;
        if (rsclear) begin
            rs_d   = '0;
            rs_t_d = '0;
        end else if (rsload) begin
            rs_d[2*WIDTH:WIDTH]   = sum;
            rs_t_d[2*WIDTH:WIDTH] = sum_t;
        end else if (rsshr) begin
            rs_d   = rs_q >> 1;
            rs_t_d = rs_t_q >> 1;
        end
        rs_t_d = rs_t_d | {(2*WIDTH+1){rs_ctl_t}};

`ifdef DATAPATH_TAINT_KILL_EN
        // Declassification: taint is dropped, data continues untouched.
        if (taint_kill) begin
            md_t_d = '0;
            mr_t_d = '0;
            rs_t_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_q   <= '0;
            md_t_q <= '0;
            mr_q   <= '0;
            mr_t_q <= '0;
            rs_q   <= '0;
            rs_t_q <= '0;
        end else begin
            md_q   <= md_d;
            md_t_q <= md_t_d;
            mr_q   <= mr_d;
            mr_t_q <= mr_t_d;
            rs_q   <= rs_d;
            rs_t_q <= rs_t_d;
        end
    end

    assign multiplierReg   = mr_q;
    assign multiplierReg_t = mr_t_q;
    assign product         = rs_q[2*WIDTH-1:0];
    assign product_t       = rs_t_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_multiplier_datapath_tainttrack.sv
// -----------------------------------------------------------------------------
// Testbench for multiplier_datapath_tainttrack at WIDTH=4. A step-level model
// tracks MD/MR/RS and their taints with integer arithmetic. Every cycle's
// outputs are compared against the model. Directed cases cover the documented
// examples, and random multiplications with random taint follow them.
// -----------------------------------------------------------------------------
module tb_multiplier_datapath_tainttrack;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           taint_kill = 1'b0;
    logic [W-1:0]   multiplicand = '0, multiplicand_t = '0;
    logic [W-1:0]   multiplier = '0, multiplier_t = '0;
    logic           mdld = 0, mdld_t = 0, mrld = 0, mrld_t = 0;
    logic           rsclear = 0, rsclear_t = 0, rsload = 0, rsload_t = 0;
    logic           rsshr = 0, rsshr_t = 0;
    logic [W-1:0]   multiplierReg, multiplierReg_t;
    logic [2*W-1:0] product, product_t;

    int n_cmp = 0;
    int n_bad = 0;
    bit inject_en = 0;

    // model state (plain integers)
    int m_md, m_md_t, m_mr, m_mr_t, m_rs, m_rs_t;

    multiplier_datapath_tainttrack #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
`ifdef DATAPATH_TAINT_KILL_EN
        .taint_kill      (taint_kill),
`endif
        .multiplicand    (multiplicand),
        .multiplicand_t  (multiplicand_t),
        .multiplier      (multiplier),
        .multiplier_t    (multiplier_t),
        .mdld            (mdld),
        .mdld_t          (mdld_t),
        .mrld            (mrld),
        .mrld_t          (mrld_t),
        .rsclear         (rsclear),
        .rsclear_t       (rsclear_t),
        .rsload          (rsload),
        .rsload_t        (rsload_t),
        .rsshr           (rsshr),
        .rsshr_t         (rsshr_t),
        .multiplierReg   (multiplierReg),
        .multiplierReg_t (multiplierReg_t),
        .product         (product),
        .product_t       (product_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".mr"},    int'(multiplierReg),   m_mr);
        chk({tag, ".mr_t"},  int'(multiplierReg_t), m_mr_t);
        chk({tag, ".prod"},  int'(product),         m_rs & 8'hFF);
        chk({tag, ".prod_t"},int'(product_t),       m_rs_t & 8'hFF);
    endtask

    task automatic model_zero();
        m_md = 0; m_md_t = 0; m_mr = 0; m_mr_t = 0; m_rs = 0; m_rs_t = 0;
    endtask

    task automatic clear_ctl();
        mdld = 0; mdld_t = 0; mrld = 0; mrld_t = 0;
        rsclear = 0; rsclear_t = 0; rsload = 0; rsload_t = 0;
        rsshr = 0; rsshr_t = 0; taint_kill = 0;
    endtask

    // One clock: optionally sprinkle control taint, predict, clock, compare.
    task automatic cycle(input string tag);
        int n_md, n_md_t, n_mr, n_mr_t, n_rs, n_rs_t, hi, src, k;
        if (inject_en && $urandom_range(0, 11) == 0) begin
            case ($urandom_range(0, 4))
                0: mdld_t = 1;
                1: mrld_t = 1;
                2: rsclear_t = 1;
                3: rsload_t = 1;
                default: rsshr_t = 1;
            endcase
        end
        n_md   = mdld ? int'(multiplicand) : m_md;
        n_md_t = (mdld ? int'(multiplicand_t) : m_md_t) | (mdld_t ? 15 : 0);
        n_mr   = mrld ? int'(multiplier) : m_mr;
        n_mr_t = (mrld ? int'(multiplier_t) : m_mr_t) | (mrld_t ? 15 : 0);
        n_rs   = m_rs;
        n_rs_t = m_rs_t;
        if (rsclear) begin
            n_rs = 0; n_rs_t = 0;
        end else if (rsload) begin
            hi   = (m_rs >> 4) + m_md;
            n_rs = (hi << 4) | (m_rs & 15);
            // upper half is tainted from the lowest tainted operand bit upward
            src = ((m_rs_t >> 4) & 15) | m_md_t;
            k = -1;
            for (int j = 0; j < 4; j++)
                if (k < 0 && ((src >> j) & 1) == 1) k = j;
            n_rs_t = m_rs_t & 15;
            if (k >= 0) n_rs_t = n_rs_t | (('h1FF >> (4 + k)) << (4 + k));
        end else if (rsshr) begin
            n_rs = m_rs >> 1; n_rs_t = m_rs_t >> 1;
        end
        if (rsclear_t || rsload_t || rsshr_t) n_rs_t = 'h1FF;
`ifdef DATAPATH_TAINT_KILL_EN
        if (taint_kill) begin n_md_t = 0; n_mr_t = 0; n_rs_t = 0; end
`endif
        @(posedge clk);
        #1;
        m_md = n_md; m_md_t = n_md_t; m_mr = n_mr; m_mr_t = n_mr_t;
        m_rs = n_rs; m_rs_t = n_rs_t;
        chk_all(tag);
        clear_ctl();
    endtask

    task automatic do_init(input int a, input int b, input int a_t, input int b_t);
        multiplicand = W'(a); multiplicand_t = W'(a_t);
        multiplier = W'(b); multiplier_t = W'(b_t);
        mdld = 1; mrld = 1; rsclear = 1;
        cycle("init");
    endtask

    task automatic mult(input int a, input int b, input int a_t, input int b_t,
                        input bit taint_last_shift);
        do_init(a, b, a_t, b_t);
        for (int i = 0; i < W; i++) begin
            if (((b >> i) & 1) == 1) begin
                rsload = 1;
                cycle("load");
            end
            rsshr = 1;
            if (taint_last_shift && i == W - 1) rsshr_t = 1;
            cycle("shr");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, b, at, bt;
        model_zero();
        clear_ctl();

        // reset state
        #12;
        chk_all("reset");
        rst = 0;
        @(posedge clk); #1;
        chk_all("idle");

        // 3 x 5, clean
        mult(3, 5, 0, 0, 0);
        chk("p3x5", int'(product), 15);
        chk("p3x5_t", int'(product_t), 0);

        // 15 x 15, carry into bit 2W
        mult(15, 15, 0, 0, 0);
        chk("p15x15", int'(product), 225);
        chk("p15x15_t", int'(product_t), 0);

        // tainted multiplicand bit 0 smears through the carry chain
        do_init(3, 1, 1, 0);
        rsload = 1;
        cycle("t_load");
        chk("t_load_t", int'(product_t), 'hF0);
        for (int i = 0; i < W; i++) begin
            rsshr = 1;
            cycle("t_shr");
        end
        chk("t_prod", int'(product), 3);
        chk("t_prod_t", int'(product_t), 'h1F);

        // tainted control on the final shift taints the whole product
        mult(3, 5, 0, 0, 1);
        chk("ctl_prod", int'(product), 15);
        chk("ctl_prod_t", int'(product_t), 'hFF);

        // control taint with the strobe idle still taints the register
        mdld_t = 1; mrld_t = 1;
        cycle("idle_t");
        chk("idle_mr_t", int'(multiplierReg_t), 'hF);

        // asynchronous reset mid-operation
        do_init(7, 6, 2, 1);
        rsshr = 1;
        cycle("pre_rst");
        #2 rst = 1;
        #1;
        model_zero();
        chk_all("async_rst");
        @(posedge clk); #2;
        rst = 0;
        @(posedge clk); #1;
        chk_all("post_rst");
        cycle("post_rst_idle");
        mult(2, 3, 0, 0, 0);
        chk("p2x3", int'(product), 6);

`ifdef DATAPATH_TAINT_KILL_EN
        do_init(3, 1, 1, 0);
        rsload = 1;
        cycle("k_load");
        for (int i = 0; i < W; i++) begin
            rsshr = 1;
            if (i == 0) taint_kill = 1;
            cycle("k_shr");
        end
        chk("kill_prod", int'(product), 3);
        chk("kill_prod_t", int'(product_t), 0);
`endif

        // random multiplications with random data and control taint
        inject_en = 1;
        for (int n = 0; n < 40; n++) begin
            a  = int'($urandom_range(0, 15));
            b  = int'($urandom_range(0, 15));
            at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 0;
            bt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 0;
            mult(a, b, at, bt, 0);
            chk("rnd_prod", int'(product), a * b);
        end
        inject_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
